// File: rtl/pow2_scaler_pipe_if.sv
// Handshake bundle for pow2_scaler_pipe.
// The producer side (in_*) and consumer side (out_*) share one interface.
// The slave modport is the scaler's view and the master modport is the environment's view.
`timescale 1ns/1ps

interface pow2_scaler_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_shamt, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output in_valid, in_data, in_shamt, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/pow2_scaler_pipe.sv
// pow2_scaler_pipe: pipelined multiply-by-2^k with signed/unsigned overflow detection.
// All arithmetic happens when a beat is captured into stage 0.
// Stages 1..STAGES-1 only delay the result.
// in_ready is combinational from out_ready through the stage chain, so a full pipe
// can accept one beat and emit one beat in the same cycle.
// Optional macro SCALER_SATURATE_EN: when an overflow occurs, the result saturates
// instead of wrapping. This happens inside stage 0 and leaves the latency unchanged.
`timescale 1ns/1ps

module pow2_scaler_pipe #(
    parameter int WIDTH  = 32,
    parameter int SHW    = 5,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pow2_scaler_pipe_if.slave     bus
);

    localparam int               LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0]            r_ovf;
    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0]            w_load;
    logic [WIDTH-1:0]             w_res_data;
    logic                         w_res_ovf;

    // Returns {ovf, result} for d * 2^k.
    // In the default build, result is the wrapped product.
    // With saturation enabled, result is the saturated value whenever ovf is set.
    function automatic logic [WIDTH:0] scale_beat(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   k,
        input logic             is_signed
    );
        logic [31:0]      kk;
        logic [WIDTH-1:0] wrapped;
        logic [WIDTH-1:0] lost_u;
        logic [WIDTH-1:0] top_s;
        logic [WIDTH-1:0] res;
        logic             ovf;
        kk     = 32'(k);
        lost_u = ZERO;
        top_s  = ZERO;
        if (kk == 32'd0) begin
            wrapped = d;
            ovf     = 1'b0;
        end else if (kk >= 32'(WIDTH)) begin
            // Every bit is shifted out, so any nonzero operand overflows in both modes.
            wrapped = ZERO;
            ovf     = (d != ZERO);
        end else begin
            wrapped = d << kk;
            // Unsigned: these are the bits pushed past the MSB.
            lost_u  = d >> (32'(WIDTH) - kk);
            // Signed: arithmetic-shift the top k+1 bits down to the bottom.
            // They must be all zeros or all ones.
            top_s   = $signed(d) >>> (32'(WIDTH) - 32'd1 - kk);
            if (is_signed) begin
                ovf = (top_s != ZERO) && (top_s != ONES);
            end else begin
                ovf = (lost_u != ZERO);
            end
        end
        res = wrapped;
`ifdef SCALER_SATURATE_EN
        if (ovf) begin
            if (!is_signed) begin
                res = ONES;
            end else if (d[WIDTH-1]) begin
                res = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res = wrapped;
        end
`endif
        return {ovf, res};
    endfunction

    assign {w_res_ovf, w_res_data} = scale_beat(bus.in_data, bus.in_shamt, bus.in_signed);

    // Stage i may load when out_ready is high, or when stage i or some later stage holds a bubble.
    always_comb begin
        logic v_full;
        v_full = 1'b1;
        w_load = {STAGES{1'b0}};
        for (int i = LAST; i >= 0; i--) begin
            v_full    = v_full & r_valid[i];
            w_load[i] = !v_full | bus.out_ready;
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[LAST];
    assign bus.out_data  = r_data[LAST];
    assign bus.out_ovf   = r_ovf[LAST];

    // Stage registers: capture into stage 0 and shift forward on advance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {STAGES{1'b0}};
            r_ovf   <= {STAGES{1'b0}};
            r_data  <= {STAGES{ZERO}};
        end else begin
            for (int i = LAST; i >= 1; i--) begin
                if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                        r_ovf[i]  <= r_ovf[i-1];
                    end
                end
            end
            if (w_load[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_data[0] <= w_res_data;
                    r_ovf[0]  <= w_res_ovf;
                end
            end
        end
    end

endmodule
